uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter that serialises one word per frame onto tx.
//  Configurable word length, parity mode and stop-bit count; baud divisor selectable at run time.
//  Uses a valid/ready handshake, so it sits directly behind a FIFO or bus register.
//  Successor to the fixed 8N1 transmitter in the serial I/O path.
// PARAMETERS
//  CLK_FREQ    50000000              system clock frequency, Hz
//  BAUD_RATE   9600                  default rate; DIV_DEFAULT = CLK_FREQ/BAUD_RATE
//  DATA_BITS   8                     word length, legal 5..9
//  PARITY      0                     0 none, 1 even, 2 odd
//  STOP_BITS   1                     legal 1 or 2
//  DIV_W       16                    baud divisor width
// PORTS
//  clk         in   1                system clock; all logic on posedge
//  rst_n       in   1                asynchronous active-low reset
//  data_in     in   DATA_BITS        word to send, LSB transmitted first
//  valid       in   1                data_in is valid
//  ready       out  1                block can accept a word (IDLE)
//  baud_div    in   DIV_W            clocks per bit; 0 selects DIV_DEFAULT
//  tx          out  1                serial line, idles high
//  busy        out  1                frame in progress (= ~ready)
//  frame_done  out  1                one-cycle pulse when the last stop bit ends
// BEHAVIOUR
//  - Reset values: tx=1, ready=1, busy=0, frame_done=0, state IDLE, counters 0. All outputs are registered.
//  - Reset mid-frame: tx returns to 1 immediately (asynchronous) and the frame is abandoned.
//  - Handshake: a word is accepted on any clk edge where valid & ready.
//    - On acceptance, capture data_in, the effective divisor and the parity bit.
//    - Parity: even = ^data_in; odd = ~^data_in.
//    - After capture, changes on data_in, valid or baud_div have no effect until the next IDLE.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - PARITY is skipped when PARITY==0.
//    - STOP repeats STOP_BITS times.
//  - Each bit holds tx for exactly div clocks, where div = (baud_div==0) ? DIV_DEFAULT : baud_div.
//    - Bit counter counts 0..div-1; the tick is asserted at count div-1, then the counter wraps to 0.
//    - div=1 is legal: one clock per bit.
//  - Latency: tx falls (start bit) on the edge after acceptance.
//  - Line levels per state:
//    - START: tx=0.
//    - DATA: tx = shift[0]; shift right on each tick; index counts 0..DATA_BITS-1.
//    - PARITY: tx = parity bit.
//    - STOP: tx=1.
//  - Last stop tick: state goes to IDLE; ready=1 and frame_done=1 together for one cycle.
//  - Back-to-back: with valid held high, the next word is accepted in that IDLE cycle.
//    - The final stop bit therefore lasts div+1 clocks.
//    - Frame period = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*div + 1 clocks.
//  - valid asserted while busy is ignored: no queueing, no error.
//  - Illegal parameter values (DATA_BITS, PARITY, STOP_BITS) fail an elaboration-time assertion.
// STRUCTURE
//  - Package uart_pkg:
//    - parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}
//    - tx_state_e {IDLE, START, DATA, PARITY, STOP}
//    - function frame_bits(DATA_BITS, PARITY, STOP_BITS)
//  - Sub-module uart_baud_gen:
//    - DIV_W-bit counter with load (clear on frame start) and tick output.
//    - Reusable by the future receiver.
//  - The top level holds the FSM, shift register, bit index and output registers.
// TESTING
//  - Reset: rst_n=0 -> tx=1, ready=1, busy=0, frame_done=0.
//    - Release, idle 100 clocks -> tx stays 1.
//  - 8N1, baud_div=4, data_in=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks.
//    - frame_done pulses at clock 40 after acceptance; ready rises the same cycle.
//  - PARITY=1, DATA_BITS=7, STOP_BITS=2, baud_div=2, data_in=7'h03 -> parity bit 0.
//    - Two stop bits high; frame = 22 clocks.
//    - Rerun with PARITY=2 -> parity bit 1.
//  - Back-to-back: valid high, words 8'h00 then 8'hFF, baud_div=3.
//    - Second start bit begins exactly 31 clocks after the first.
//    - busy drops for exactly 1 cycle between the frames.
//  - Mid-frame changes: during DATA, change data_in and baud_div and pulse valid.
//    - Frame is unchanged; no second frame starts.
//  - Boundaries: baud_div=0 -> bit width = DIV_DEFAULT (5208 clocks).
//    - baud_div=1 -> 1-clock bits.
//    - rst_n low mid-DATA -> tx=1 within the reset cycle; next send is clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and the future receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int MAX_DATA_BITS = 9;

  function automatic int frame_bits(int data_bits, int parity, int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

  // Callers zero-extend narrower words; extra zeros do not change the XOR.
  function automatic logic parity_bit(parity_e mode, logic [MAX_DATA_BITS-1:0] word);
    case (mode)
      PAR_EVEN: return ^word;
      PAR_ODD:  return ~^word;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div-1 and flags the last clock of each bit; load restarts a period.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  assign tick = (cnt_r == (div - DIV_W'(1)));

  // Period counter, cleared at frame start and after every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with build-time frame format and run-time baud divisor, valid/ready input.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  input  logic [DIV_W-1:0]     baud_div,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(CLK_FREQ / BAUD_RATE);
  localparam parity_e          PAR_MODE    = parity_e'(PARITY);
  localparam logic [3:0]       IDX_LAST    = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST   = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_cfg: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  tx_state_e            state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DIV_W-1:0]     div_r;
  logic                 par_r;
  logic [3:0]           idx_r;
  logic                 stop_r;
  logic                 accept_s;
  logic                 tick_s;
  logic [DIV_W-1:0]     eff_div_s;

  assign accept_s  = valid & ready;
  assign eff_div_s = (baud_div == '0) ? DIV_DEFAULT : baud_div;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_s),
    .div   (div_r),
    .tick  (tick_s)
  );

  // Frame sequencer; ready/busy/tx/frame_done are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      div_r      <= '0;
      par_r      <= 1'b0;
      idx_r      <= 4'd0;
      stop_r     <= 1'b0;
      tx         <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid) begin
            state_r <= START;
            shift_r <= data_in;
            div_r   <= eff_div_s;
            par_r   <= parity_bit(PAR_MODE, MAX_DATA_BITS'(data_in));
            tx      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_r <= DATA;
            tx      <= shift_r[0];
            shift_r <= shift_r >> 1;
            idx_r   <= 4'd0;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (idx_r != IDX_LAST) begin
              tx      <= shift_r[0];
              shift_r <= shift_r >> 1;
              idx_r   <= idx_r + 4'd1;
            end else if (PAR_MODE != PAR_NONE) begin
              state_r <= uart_pkg::PARITY;
              tx      <= par_r;
            end else begin
              state_r <= STOP;
              tx      <= 1'b1;
              stop_r  <= 1'b0;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick_s) begin
            state_r <= STOP;
            tx      <= 1'b1;
            stop_r  <= 1'b0;
          end
        end
        STOP: begin
          if (tick_s) begin
            if (stop_r == STOP_LAST) begin
              state_r    <= IDLE;
              ready      <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              stop_r <= stop_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx      <= 1'b1;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
